// File: rtl/cpu_pkg.sv
// Shared core definitions: scoreboard entry layout, default widths and the x0 index.
package cpu_pkg;

  localparam int unsigned CPU_REG_ADDR_W = 5;
  localparam int unsigned CPU_DATA_W     = 32;

  localparam logic [CPU_REG_ADDR_W-1:0] CPU_X0 = '0;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic                      valid;
    logic [CPU_REG_ADDR_W-1:0] rd;
    logic                      wen;
    logic                      is_load;
  } sb_entry_t;

endpackage

// File: rtl/fwd_match.sv
// Per-source hazard resolution: youngest matching in-flight writer, ready check
// and result select for one decode operand.
module fwd_match
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W           = CPU_DATA_W,
  parameter int unsigned REG_ADDR_W       = CPU_REG_ADDR_W,
  parameter int unsigned STAGES           = 3,
  parameter int unsigned LOAD_READY_STAGE = 1
) (
  input  sb_entry_t [STAGES-1:0]        i_entries,
  input  logic                          i_id_valid,
  input  logic                          i_src_used,
  input  logic [REG_ADDR_W-1:0]         i_src,
  input  logic [STAGES*DATA_W-1:0]      i_stage_result,
  output logic                          o_fwd_en_c,
  output logic [DATA_W-1:0]             o_fwd_data_c,
  output logic                          o_stall_c
);

  logic                      w_needed;
  logic                      w_hit;
  logic                      w_ready;
  logic [DATA_W-1:0]         w_data;
  logic [CPU_REG_ADDR_W-1:0] w_src;

  assign w_src    = CPU_REG_ADDR_W'(i_src);
  assign w_needed = i_id_valid & i_src_used & (w_src != CPU_X0);

  // Scan from stage 0 upward; the first hit is the youngest writer.
  always_comb begin
    w_hit   = 1'b0;
    w_ready = 1'b0;
    w_data  = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (!w_hit && i_entries[k].valid && i_entries[k].wen && (i_entries[k].rd == w_src)) begin
        w_hit   = 1'b1;
        w_ready = !i_entries[k].is_load || (k >= LOAD_READY_STAGE);
        w_data  = i_stage_result[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    o_fwd_en_c   = 1'b0;
    o_fwd_data_c = '0;
    o_stall_c    = 1'b0;
    if (w_needed && w_hit) begin
      if (w_ready) begin
        o_fwd_en_c   = 1'b1;
        o_fwd_data_c = w_data;
      end else begin
        o_stall_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: shadow pipeline of in-flight destinations,
// operand forwarding, load-use stall and a saturating stall-cycle counter.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W           = CPU_DATA_W,
  parameter int unsigned REG_ADDR_W       = CPU_REG_ADDR_W,
  parameter int unsigned STAGES           = 3,
  parameter int unsigned LOAD_READY_STAGE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic                     id_rs1_used,
  input  logic                     id_rs2_used,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic                     id_wen,
  input  logic                     id_is_load,
  input  logic                     flush,
  input  logic [STAGES*DATA_W-1:0] stage_result,
  output logic                     rs1_fwd_en,
  output logic                     rs2_fwd_en,
  output logic [DATA_W-1:0]        rs1_fwd_data,
  output logic [DATA_W-1:0]        rs2_fwd_data,
  output logic                     stall,
  output logic [31:0]              stall_count
);

  localparam logic [31:0] CNT_MAX = '1;

  sb_entry_t [STAGES-1:0] r_entries;
  sb_entry_t [STAGES-1:0] w_entries_nxt;
  logic [31:0]            r_stall_count;

  logic w_rs1_stall;
  logic w_rs2_stall;
  logic w_stall;

  fwd_match #(
    .DATA_W           (DATA_W),
    .REG_ADDR_W       (REG_ADDR_W),
    .STAGES           (STAGES),
    .LOAD_READY_STAGE (LOAD_READY_STAGE)
  ) u_rs1_match (
    .i_entries      (r_entries),
    .i_id_valid     (id_valid),
    .i_src_used     (id_rs1_used),
    .i_src          (id_rs1),
    .i_stage_result (stage_result),
    .o_fwd_en_c     (rs1_fwd_en),
    .o_fwd_data_c   (rs1_fwd_data),
    .o_stall_c      (w_rs1_stall)
  );

  fwd_match #(
    .DATA_W           (DATA_W),
    .REG_ADDR_W       (REG_ADDR_W),
    .STAGES           (STAGES),
    .LOAD_READY_STAGE (LOAD_READY_STAGE)
  ) u_rs2_match (
    .i_entries      (r_entries),
    .i_id_valid     (id_valid),
    .i_src_used     (id_rs2_used),
    .i_src          (id_rs2),
    .i_stage_result (stage_result),
    .o_fwd_en_c     (rs2_fwd_en),
    .o_fwd_data_c   (rs2_fwd_data),
    .o_stall_c      (w_rs2_stall)
  );

  assign w_stall = w_rs1_stall | w_rs2_stall;
  assign stall   = w_stall;

  // Shift: decode enters stage 0 unless stalled or flushed; flush also kills stage 0.
  always_comb begin
    w_entries_nxt    = '0;
    if (id_valid && !w_stall && !flush) begin
      w_entries_nxt[0] = '{valid: 1'b1, rd: CPU_REG_ADDR_W'(id_rd), wen: id_wen, is_load: id_is_load};
    end
    for (int unsigned k = 1; k < STAGES; k++) begin
      if (!(flush && (k == 1))) begin
        w_entries_nxt[k] = r_entries[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entries <= '0;
    end else begin
      r_entries <= w_entries_nxt;
    end
  end

  // A flushed cycle inserts a bubble and is not a stall cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall && !flush && (r_stall_count != CNT_MAX)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios with literal
// expectations, then randomized traffic against a behavioural scoreboard model.
module tb_hazard_scoreboard;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned NS  = 3;
  localparam int unsigned LRS = 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           id_valid, id_rs1_used, id_rs2_used, id_wen, id_is_load, flush;
  logic [AW-1:0]  id_rs1, id_rs2, id_rd;
  logic [NS*DW-1:0] stage_result;
  logic           rs1_fwd_en, rs2_fwd_en, stall;
  logic [DW-1:0]  rs1_fwd_data, rs2_fwd_data;
  logic [31:0]    stall_count;

  int nvec = 0;
  int nerr = 0;

  hazard_scoreboard #(
    .DATA_W(DW), .REG_ADDR_W(AW), .STAGES(NS), .LOAD_READY_STAGE(LRS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load),
    .flush(flush), .stage_result(stage_result),
    .rs1_fwd_en(rs1_fwd_en), .rs2_fwd_en(rs2_fwd_en),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
    .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Model: list of in-flight instructions, index 0 = youngest.
  typedef struct {
    bit v;
    int rd;
    bit wen;
    bit ld;
  } ment_t;

  ment_t       m [NS];
  longint      m_cnt;

  function automatic void model_src(input int src, input bit used,
                                    output bit en, output bit st, output logic [31:0] d);
    en = 0; st = 0; d = 0;
    if (!(id_valid === 1'b1 && used && src != 0)) return;
    for (int k = 0; k < NS; k++) begin
      if (m[k].v && m[k].wen && m[k].rd == src) begin
        if (m[k].ld && k < LRS) st = 1;
        else begin
          en = 1;
          d  = stage_result[k*DW +: DW];
        end
        return;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit e1, s1, e2, s2, st;
    logic [31:0] d1, d2;
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) m[k] = '{v: 0, rd: 0, wen: 0, ld: 0};
      m_cnt = 0;
    end else begin
      model_src(int'(id_rs1), id_rs1_used, e1, s1, d1);
      model_src(int'(id_rs2), id_rs2_used, e2, s2, d2);
      st = s1 | s2;
      if (st && !flush && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      for (int k = NS - 1; k >= 1; k--) m[k] = m[k-1];
      if (flush) m[1] = '{v: 0, rd: 0, wen: 0, ld: 0};
      if (id_valid && !st && !flush)
        m[0] = '{v: 1, rd: int'(id_rd), wen: id_wen, ld: id_is_load};
      else
        m[0] = '{v: 0, rd: 0, wen: 0, ld: 0};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    bit e1, s1, e2, s2;
    logic [31:0] d1, d2;
    model_src(int'(id_rs1), id_rs1_used, e1, s1, d1);
    model_src(int'(id_rs2), id_rs2_used, e2, s2, d2);
    check("cmp_rs1_en",   32'(rs1_fwd_en),   32'(e1));
    check("cmp_rs1_data", rs1_fwd_data,      d1);
    check("cmp_rs2_en",   32'(rs2_fwd_en),   32'(e2));
    check("cmp_rs2_data", rs2_fwd_data,      d2);
    check("cmp_stall",    32'(stall),        32'(s1 | s2));
    check("cmp_count",    stall_count,       m_cnt[31:0]);
  end

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit wen, input bit ld, input bit fl);
    id_valid = v; id_rs1 = AW'(rs1); id_rs1_used = u1; id_rs2 = AW'(rs2); id_rs2_used = u2;
    id_rd = AW'(rd); id_wen = wen; id_is_load = ld; flush = fl;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    stage_result = '0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    #1;
    check("rst_count", stall_count, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    cyc();

    // EX forwarding
    set_id(1, 0, 0, 0, 0, 5, 1, 0, 0); cyc();
    set_id(1, 5, 1, 0, 0, 0, 0, 0, 0);
    stage_result = {32'h0, 32'h0, 32'h0000_00AA}; #1;
    check("ex_fwd_en",    32'(rs1_fwd_en), 32'd1);
    check("ex_fwd_data",  rs1_fwd_data, 32'h0000_00AA);
    check("ex_fwd_stall", 32'(stall), 32'd0);
    cyc();

    // Youngest writer wins
    set_id(1, 0, 0, 0, 0, 5, 1, 0, 0); cyc();
    set_id(1, 0, 0, 0, 0, 5, 1, 0, 0); cyc();
    set_id(1, 0, 0, 5, 1, 0, 0, 0, 0);
    stage_result = {32'h0, 32'h11, 32'h22}; #1;
    check("young_en",   32'(rs2_fwd_en), 32'd1);
    check("young_data", rs2_fwd_data, 32'h22);
    cyc();

    // Load-use: one stall cycle, then forwarded from stage 1
    set_id(1, 0, 0, 0, 0, 7, 1, 1, 0); cyc();
    set_id(1, 7, 1, 0, 0, 0, 0, 0, 0);
    stage_result = {32'h0, 32'h77, 32'h66}; #1;
    check("lu_stall",  32'(stall), 32'd1);
    check("lu_en0",    32'(rs1_fwd_en), 32'd0);
    cyc();
    check("lu_count",  stall_count, 32'd1);
    check("lu_stall2", 32'(stall), 32'd0);
    check("lu_en1",    32'(rs1_fwd_en), 32'd1);
    check("lu_data",   rs1_fwd_data, 32'h77);
    cyc();

    // x0 destination and unused source
    set_id(1, 0, 0, 0, 0, 0, 1, 0, 0); cyc();
    set_id(1, 0, 1, 0, 0, 0, 0, 0, 0); #1;
    check("x0_en",    32'(rs1_fwd_en), 32'd0);
    check("x0_stall", 32'(stall), 32'd0);
    cyc();
    set_id(1, 0, 0, 0, 0, 6, 1, 0, 0); cyc();
    set_id(1, 0, 0, 6, 0, 0, 0, 0, 0); #1;
    check("unused_en", 32'(rs2_fwd_en), 32'd0);
    cyc();

    // Flush squashes decode insert
    set_id(1, 0, 0, 0, 0, 9, 1, 0, 1); cyc();
    set_id(1, 9, 1, 0, 0, 0, 0, 0, 0); #1;
    check("flush_en", 32'(rs1_fwd_en), 32'd0);
    cyc();

    // Flush during load-use: no stall cycle counted, load killed
    set_id(1, 0, 0, 0, 0, 7, 1, 1, 0); cyc();
    set_id(1, 7, 1, 0, 0, 0, 0, 0, 1); cyc();
    check("flush_count", stall_count, 32'd1);
    set_id(1, 7, 1, 0, 0, 0, 0, 0, 0); #1;
    check("flush_kill_en",    32'(rs1_fwd_en), 32'd0);
    check("flush_kill_stall", 32'(stall), 32'd0);
    cyc();

    // Asynchronous reset during an active stall
    set_id(1, 0, 0, 0, 0, 3, 1, 1, 0); cyc();
    set_id(1, 3, 1, 0, 0, 0, 0, 0, 0); #1;
    check("rs_pre_stall", 32'(stall), 32'd1);
    rst_n = 1'b0; #1;
    check("rs_stall", 32'(stall), 32'd0);
    check("rs_en",    32'(rs1_fwd_en), 32'd0);
    check("rs_data",  rs1_fwd_data, 32'd0);
    check("rs_count", stall_count, 32'd0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    set_id(1, 0, 0, 0, 0, 4, 1, 0, 0); cyc();
    set_id(1, 4, 1, 0, 0, 0, 0, 0, 0);
    stage_result = {32'h3, 32'h2, 32'h4444_0001}; #1;
    check("post_rst_en",   32'(rs1_fwd_en), 32'd1);
    check("post_rst_data", rs1_fwd_data, 32'h4444_0001);
    cyc();

    // Randomized traffic checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      set_id($urandom_range(0, 9) < 8,
             int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
             int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
             int'($urandom_range(0, 7)), $urandom_range(0, 9) < 8,
             $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
      stage_result = {$urandom(), $urandom(), $urandom()};
      cyc();
    end

    rst_n = 1'b1;
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
